// File: rtl/joy_chain_scanner_pkg.sv
// Shared types for the serial joystick chain scanner.
// FSM state encoding and the shadow-bit to joystick-word map.
package joy_chain_scanner_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_PUBLISH = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

    localparam int MAP_BITS = 24;

    // word: 0 = joy1, 1 = joy2; idx: bit within that word
    typedef struct packed {
        logic       word;
        logic [3:0] idx;
    } map_t;

    function automatic map_t bit_map(input logic [4:0] i);
        map_t       m;
        logic [2:0] k;
        k      = i[2:0];
        m.word = (i >= 5'd8) && (i <= 5'd19);
        m.idx  = 4'd0;
        if (i < 5'd16) begin
            m.idx = (k == 3'd0) ? 4'd8 : 4'd7 - {1'b0, k};
        end else begin
            unique case (i[1:0])
                2'd0: m.idx = 4'd10;
                2'd1: m.idx = 4'd11;
                2'd2: m.idx = 4'd9;
                2'd3: m.idx = 4'd7;
                default: m.idx = 4'd0;
            endcase
        end
        return m;
    endfunction

    // Returns {joy2, joy1} for a captured frame
    function automatic logic [23:0] map_frame(input logic [MAP_BITS-1:0] sh);
        logic [11:0] j1;
        logic [11:0] j2;
        map_t        m;
        j1 = '1;
        j2 = '1;
        for (int i = 0; i < MAP_BITS; i++) begin
            m = bit_map(5'(i));
            if (m.word) j2[m.idx] = sh[i];
            else        j1[m.idx] = sh[i];
        end
        return {j2, j1};
    endfunction

endpackage

// File: rtl/joy_chain_scanner_sync.sv
// Two-flop synchroniser for the asynchronous chain data pin.
// Idles high so a reset never looks like a pressed button.
module joy_bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // shift the raw pin through two stages
    always_comb begin
        sync_d = {sync_q[0], d};
    end

    // synchroniser register, released high
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= sync_d;
    end

    assign q = sync_q[1];

endmodule

// File: rtl/joy_chain_scanner.sv
// Scans a 74HC165-style joystick chain on a single clock with a tick enable.
// Two identical consecutive frames are required before the joystick words move.
module joy_chain_scanner
    import joy_chain_scanner_pkg::*;
#(
    parameter int CLK_DIV   = 8,
    parameter int NBITS     = 24,
    parameter int GAP_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [11:0] joy1,
    output logic [11:0] joy2,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NBITS + 1);
    localparam int TW = $clog2(GAP_TICKS + 1) < 1 ? 1 : $clog2(GAP_TICKS + 1);

    state_e           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [NBITS-1:0] shadow_q, shadow_d;
    logic [NBITS-1:0] prev_q, prev_d;
    logic [11:0]      joy1_q, joy1_d;
    logic [11:0]      joy2_q, joy2_d;
    logic             fv_q, fv_d;
    logic             fe_q, fe_d;
    logic             joy_clk_q, joy_clk_d;
    logic             joy_load_q, joy_load_d;
    logic             data_s;
    logic             tick;
    logic [23:0]      frame_w;

    joy_bit_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (joy_data),
        .q     (data_s)
    );

    assign tick    = (div_q == DW'(CLK_DIV - 1));
    assign frame_w = map_frame(MAP_BITS'(shadow_q));

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            div_q      <= '0;
            tcnt_q     <= '0;
            bitcnt_q   <= '0;
            shadow_q   <= '1;
            prev_q     <= '1;
            joy1_q     <= 12'hFFF;
            joy2_q     <= 12'hFFF;
            fv_q       <= 1'b0;
            fe_q       <= 1'b0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tcnt_q     <= tcnt_d;
            bitcnt_q   <= bitcnt_d;
            shadow_q   <= shadow_d;
            prev_q     <= prev_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            fv_q       <= fv_d;
            fe_q       <= fe_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
        end
    end

    // next-state: load, shift, publish, gap
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:
                if (tick && tcnt_q == TW'(1)) state_d = ST_SHIFT;
            ST_SHIFT:
                if (tick && joy_clk_q && bitcnt_q == BW'(NBITS))
                    state_d = ST_PUBLISH;
            ST_PUBLISH:
                state_d = ST_GAP;
            ST_GAP:
                if (tick && tcnt_q == TW'(GAP_TICKS - 1)) state_d = ST_LOAD;
            default:
                state_d = ST_LOAD;
        endcase
    end

    // pin drive, bit capture and frame filtering per state
    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        tcnt_d     = tcnt_q;
        bitcnt_d   = bitcnt_q;
        shadow_d   = shadow_q;
        prev_d     = prev_q;
        joy1_d     = joy1_q;
        joy2_d     = joy2_q;
        fv_d       = 1'b0;
        fe_d       = 1'b0;
        joy_clk_d  = joy_clk_q;
        joy_load_d = joy_load_q;
        unique case (state_q)
            ST_LOAD: begin
                joy_load_d = 1'b0;
                joy_clk_d  = 1'b0;
                if (tick) begin
                    if (tcnt_q == TW'(1)) begin
                        tcnt_d     = '0;
                        joy_load_d = 1'b1;
                        bitcnt_d   = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    joy_clk_d = ~joy_clk_q;
                    // rising edge: take the bit shown since the last edge
                    if (!joy_clk_q) begin
                        shadow_d[bitcnt_q] = data_s;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            ST_PUBLISH: begin
                prev_d = shadow_q;
                if (shadow_q == prev_q) begin
                    joy1_d = frame_w[11:0];
                    joy2_d = frame_w[23:12];
                    fv_d   = 1'b1;
                end else begin
                    fe_d = 1'b1;
                end
            end
            ST_GAP: begin
                joy_load_d = 1'b1;
                joy_clk_d  = 1'b0;
                if (tick) begin
                    if (tcnt_q == TW'(GAP_TICKS - 1)) begin
                        tcnt_d     = '0;
                        joy_load_d = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign joy_clk     = joy_clk_q;
    assign joy_load    = joy_load_q;
    assign joy1        = joy1_q;
    assign joy2        = joy2_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;

endmodule

// File: tb/tb_joy_chain_scanner.sv
// Bench for joy_chain_scanner: a 74HC165 chain model feeds the DUT and a
// frame-level reference model predicts every published or rejected frame.
module tb_joy_chain_scanner;

    localparam int CLK_DIV   = 8;
    localparam int NBITS     = 24;
    localparam int GAP_TICKS = 4;
    localparam int PERIOD    = (2 + 2 * NBITS + GAP_TICKS) * CLK_DIV;
    localparam int DLY       = 2 * CLK_DIV - 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        joy_data = 1'b1;
    logic        joy_clk;
    logic        joy_load;
    logic [11:0] joy1;
    logic [11:0] joy2;
    logic        frame_valid;
    logic        frame_err;

    joy_chain_scanner #(
        .CLK_DIV   (CLK_DIV),
        .NBITS     (NBITS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_data    (joy_data),
        .joy_clk     (joy_clk),
        .joy_load    (joy_load),
        .joy1        (joy1),
        .joy2        (joy2),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference mapping: shadow index -> (word, bit)
    int unsigned map_w [24] = '{0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,
                                1,1,1,1, 0,0,0,0};
    int unsigned map_b [24] = '{8,6,5,4,3,2,1,0, 8,6,5,4,3,2,1,0,
                                10,11,9,7, 10,11,9,7};

    function automatic void ref_map(input logic [23:0] p,
                                    output logic [11:0] a,
                                    output logic [11:0] b);
        a = 12'hFFF;
        b = 12'hFFF;
        for (int i = 0; i < 24; i++) begin
            if (map_w[i] == 0) a[map_b[i]] = p[i];
            else               b[map_b[i]] = p[i];
        end
    endfunction

    typedef struct {
        bit          ok;
        logic [11:0] j1;
        logic [11:0] j2;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] chain_pat = 24'hFFFFFF;
    bit          delay_mode = 0;
    logic [23:0] m_prev = 24'hFFFFFF;
    logic [11:0] m_j1 = 12'hFFF;
    logic [11:0] m_j2 = 12'hFFF;

    // 74HC165 chain model with optional late data presentation
    logic [23:0] sr = 24'hFFFFFF;
    logic [31:0] hist = '1;
    logic        cm_last_clk = 1'b0;
    always @(negedge clk) begin
        if (!joy_load) sr = chain_pat;
        else if (joy_clk && !cm_last_clk) sr = {1'b1, sr[23:1]};
        cm_last_clk = joy_clk;
        hist = {hist[30:0], sr[0]};
        joy_data = delay_mode ? hist[DLY] : sr[0];
    end

    // Monitor: predicts on load, checks on publish, checks pin timing
    int   cyc = 0;
    logic last_load = 1'b1;
    logic last_jc = 1'b0;
    int   load_cnt = 0;
    bit   steady = 0;
    int   rises = 0;
    int   last_rise = 0;
    bit   have_pulse = 0;
    int   last_pulse = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            last_load  = 1'b1;
            last_jc    = 1'b0;
            load_cnt   = 0;
            steady     = 0;
            rises      = 0;
            have_pulse = 0;
        end else begin
            if (!joy_load && last_load) begin
                if (chain_pat == m_prev) begin
                    e.ok = 1;
                    ref_map(chain_pat, m_j1, m_j2);
                end else begin
                    e.ok = 0;
                end
                e.j1   = m_j1;
                e.j2   = m_j2;
                m_prev = chain_pat;
                sb.push_back(e);
                rises = 0;
            end
            if (!joy_load) load_cnt++;
            if (joy_load && !last_load) begin
                if (steady) chk("load_low_len", load_cnt, 2 * CLK_DIV);
                load_cnt = 0;
            end
            if (joy_clk && !last_jc) begin
                rises++;
                if (rises > 1) chk("jclk_spacing", cyc - last_rise, 2 * CLK_DIV);
                last_rise = cyc;
            end
            if (frame_valid || frame_err) begin
                chk("pulse_excl", frame_valid & frame_err, 0);
                chk("rise_count", rises, NBITS);
                if (have_pulse) chk("frame_period", cyc - last_pulse, PERIOD);
                have_pulse = 1;
                last_pulse = cyc;
                steady     = 1;
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", frame_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_valid", frame_valid, e.ok);
                    chk("sb_joy1", joy1, e.j1);
                    chk("sb_joy2", joy2, e.j2);
                end
            end
            last_load = joy_load;
            last_jc   = joy_clk;
        end
    end

    task automatic wait_pulse();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(frame_valid || frame_err) && n < 2 * PERIOD);
        if (n >= 2 * PERIOD) chk("pulse_timeout", frame_valid | frame_err, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset  = 1'b1;
        sb.delete();
        m_prev = 24'hFFFFFF;
        m_j1   = 12'hFFF;
        m_j2   = 12'hFFF;
        @(posedge clk); #1;
        chk("rst_joy_load", joy_load, 1);
        chk("rst_joy_clk", joy_clk, 0);
        chk("rst_joy1", joy1, 12'hFFF);
        chk("rst_joy2", joy2, 12'hFFF);
        chk("rst_pulses", {frame_valid, frame_err}, 0);
        reset = 1'b0;
    endtask

    task automatic random_frames(input int n);
        for (int i = 0; i < n; i++) begin
            wait_pulse();
            if ($urandom_range(1, 0) == 1) begin
                chain_pat = 24'($urandom);
                if ($urandom_range(1, 0) == 1) chain_pat = chain_pat | 24'hF0F0F0;
            end
        end
    endtask

    initial begin
        logic lj;
        int   n;
        int   r;
        reset = 1'b1;
        do_reset();

        // all ones: every frame publishes FFF
        repeat (3) wait_pulse();
        chk("t1_joy1", joy1, 12'hFFF);
        chk("t1_joy2", joy2, 12'hFFF);

        // P1 start pressed
        chain_pat = 24'hFFFFFE;
        wait_pulse();
        chk("t2_first_err", frame_err, 1);
        chk("t2_first_joy1", joy1, 12'hFFF);
        wait_pulse();
        chk("t2_second_valid", frame_valid, 1);
        chk("t2_joy1", joy1, 12'hEFF);
        chk("t2_joy2", joy2, 12'hFFF);

        // only bit 17 low
        chain_pat = ~(24'h1 << 17);
        repeat (2) wait_pulse();
        chk("t3_joy2", joy2, 12'h7FF);
        chk("t3_joy1", joy1, 12'hFFF);

        // toggling bit every frame: always rejected
        for (int i = 0; i < 4; i++) begin
            chain_pat = chain_pat ^ 24'h000020;
            wait_pulse();
            chk("t4_err", frame_err, 1);
            chk("t4_hold_joy2", joy2, 12'h7FF);
        end

        // reset after 10 shifted bits
        chain_pat = 24'($urandom) & 24'hFFFFF7;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (joy_load && n < 2 * PERIOD);
        chk("t5_load_seen", joy_load, 0);
        r  = 0;
        lj = joy_clk;
        n  = 0;
        while (r < 10 && n < 2 * PERIOD) begin
            @(posedge clk); #1;
            n++;
            if (joy_clk && !lj) r++;
            lj = joy_clk;
        end
        chk("t5_ten_bits", r, 10);
        do_reset();
        wait_pulse();
        chk("t5_first_err", frame_err, 1);
        wait_pulse();
        chk("t5_second_valid", frame_valid, 1);

        // late data presentation, random frames
        delay_mode = 1;
        random_frames(10);
        delay_mode = 0;
        random_frames(8);
        wait_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
